// File: rtl/proc_decode_pipe.sv
// proc_decode_pipe: decode stage for the 16-bit ISA.
// This stage holds the 8-entry register file, which has one write-back port.
// It decodes the destination and immediate fields.
// A per-register pending-write scoreboard stalls reads of results that are still in flight.
// Results are registered into the ID/EX pipeline register under a valid/ready handshake.
// Optional feature: define DECODE_BYPASS_EN to forward a same-cycle write-back
// to the operand reads and to waive the last-pending-write hazard.
module proc_decode_pipe #(
  parameter int DATA_W = 16,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] inc_pc,
  input  logic              reg_write,
  input  logic              reg_dst,
  input  logic              upper_dest,
  input  logic              pc_r7,
  input  logic              sign_ext,
  input  logic              uses_rs,
  input  logic              uses_rt,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm5,
  output logic [DATA_W-1:0] out_imm8,
  output logic [2:0]        out_dest,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] out_inc_pc,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              err
);

`ifdef DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [PEND_W-1:0] PEND_ZERO = '0;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_NEAR = PEND_MAX - PEND_ONE;

  // ID/EX pipeline register
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_rs_data_reg;
  logic [DATA_W-1:0] out_rt_data_reg;
  logic [DATA_W-1:0] out_imm5_reg;
  logic [DATA_W-1:0] out_imm8_reg;
  logic [2:0]        out_dest_reg;
  logic              out_reg_write_reg;
  logic [DATA_W-1:0] out_inc_pc_reg;
  logic              err_reg;

  // Current register file contents and pending counts, one element per register
  logic [DATA_W-1:0] rf_val   [8];
  logic [PEND_W-1:0] pend_val [8];

  logic [2:0]        rs_sel;
  logic [2:0]        rt_sel;
  logic [2:0]        dest_sel;
  logic [DATA_W-1:0] imm5_ext;
  logic [DATA_W-1:0] imm8_ext;
  logic              rs_wb_hit;
  logic              rt_wb_hit;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_haz;
  logic              rt_haz;
  logic              struct_stall;
  logic              accept_fire;
  logic              retire_fire;
  logic              retire_inc;
  logic              wb_underflow;
  logic              unused_bits;

  assign unused_bits = &{1'b0, instr[15:11]};

  assign rs_sel = instr[10:8];
  assign rt_sel = instr[7:5];

  // Destination field selection: r7 link, then the upper field, then the middle field, then the low field
  always_comb begin
    dest_sel = instr[4:2];
    if (pc_r7)
      dest_sel = 3'b111;
    else if (upper_dest)
      dest_sel = instr[10:8];
    else if (reg_dst)
      dest_sel = instr[7:5];
  end

  assign imm5_ext = sign_ext ? {{(DATA_W-5){instr[4]}}, instr[4:0]}
                             : {{(DATA_W-5){1'b0}}, instr[4:0]};
  assign imm8_ext = sign_ext ? {{(DATA_W-8){instr[7]}}, instr[7:0]}
                             : {{(DATA_W-8){1'b0}}, instr[7:0]};

  // Operand reads.
  // When forwarding is built in, a same-cycle write-back to the read register replaces the stored value.
  assign rs_wb_hit = wb_en && (wb_sel == rs_sel);
  assign rt_wb_hit = wb_en && (wb_sel == rt_sel);
  assign rs_data   = (BYPASS && rs_wb_hit) ? wb_data : rf_val[rs_sel];
  assign rt_data   = (BYPASS && rt_wb_hit) ? wb_data : rf_val[rt_sel];

  // RAW hazards.
  // A read is blocked by an outstanding counted write.
  // A read is also blocked by a writer that currently sits in ID/EX, which has not been counted yet.
  assign rs_haz = uses_rs &&
    (((pend_val[rs_sel] != PEND_ZERO) &&
      !(BYPASS && (pend_val[rs_sel] == PEND_ONE) && rs_wb_hit)) ||
     (out_valid_reg && out_reg_write_reg && (out_dest_reg == rs_sel)));
  assign rt_haz = uses_rt &&
    (((pend_val[rt_sel] != PEND_ZERO) &&
      !(BYPASS && (pend_val[rt_sel] == PEND_ONE) && rt_wb_hit)) ||
     (out_valid_reg && out_reg_write_reg && (out_dest_reg == rt_sel)));

  // A writer must not push its destination counter past saturation.
  // This includes the count that the ID/EX writer will add when it retires.
  assign struct_stall = reg_write &&
    ((pend_val[dest_sel] == PEND_MAX) ||
     (out_valid_reg && out_reg_write_reg && (out_dest_reg == dest_sel) &&
      (pend_val[dest_sel] == PEND_NEAR)));

  assign in_ready    = !rs_haz && !rt_haz && !struct_stall && (!out_valid_reg || out_ready);
  assign accept_fire = in_valid && in_ready;
  // A flushed instruction never retires, so it never reaches the scoreboard
  assign retire_fire = out_valid_reg && out_ready && !flush;
  assign retire_inc  = retire_fire && out_reg_write_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_reg
      logic [DATA_W-1:0] rf_reg;
      logic [PEND_W-1:0] pend_reg;
      logic              inc_hit;
      logic              dec_hit;

      assign inc_hit      = retire_inc && (out_dest_reg == 3'(gi));
      assign dec_hit      = wb_en && (wb_sel == 3'(gi));
      assign rf_val[gi]   = rf_reg;
      assign pend_val[gi] = pend_reg;

      // Register write on the write-back strobe
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          rf_reg <= '0;
        else if (dec_hit)
          rf_reg <= wb_data;
      end

      // Pending-write counter.
      // Up on a retiring writer, down on write-back, unchanged when both happen, never below zero.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          pend_reg <= '0;
        else if (inc_hit && !dec_hit)
          pend_reg <= pend_reg + PEND_ONE;
        else if (dec_hit && !inc_hit && (pend_reg != PEND_ZERO))
          pend_reg <= pend_reg - PEND_ONE;
      end
    end
  endgenerate

  // Write-back to a register with nothing outstanding is an underflow
  assign wb_underflow = wb_en && (pend_val[wb_sel] == PEND_ZERO) &&
                        !(retire_inc && (out_dest_reg == wb_sel));

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_reg <= 1'b0;
    else if (wb_underflow)
      err_reg <= 1'b1;
  end

  // ID/EX register.
  // Flush beats accept. Fields hold while the stage is not accepting, which keeps them stable under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg     <= 1'b0;
      out_rs_data_reg   <= '0;
      out_rt_data_reg   <= '0;
      out_imm5_reg      <= '0;
      out_imm8_reg      <= '0;
      out_dest_reg      <= '0;
      out_reg_write_reg <= 1'b0;
      out_inc_pc_reg    <= '0;
    end else begin
      if (flush)
        out_valid_reg <= 1'b0;
      else if (accept_fire)
        out_valid_reg <= 1'b1;
      else if (out_ready)
        out_valid_reg <= 1'b0;

      if (accept_fire && !flush) begin
        out_rs_data_reg   <= rs_data;
        out_rt_data_reg   <= rt_data;
        out_imm5_reg      <= imm5_ext;
        out_imm8_reg      <= imm8_ext;
        out_dest_reg      <= dest_sel;
        out_reg_write_reg <= reg_write;
        out_inc_pc_reg    <= inc_pc;
      end
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_rs_data   = out_rs_data_reg;
  assign out_rt_data   = out_rt_data_reg;
  assign out_imm5      = out_imm5_reg;
  assign out_imm8      = out_imm8_reg;
  assign out_dest      = out_dest_reg;
  assign out_reg_write = out_reg_write_reg;
  assign out_inc_pc    = out_inc_pc_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_proc_decode_pipe.sv
// Testbench for proc_decode_pipe.
// It runs a table of decode vectors plus hand-written multi-cycle sequences.
// A queue-based scoreboard follows every instruction from accept to retire.
module tb_proc_decode_pipe;
  localparam int DATA_W = 16;
  localparam int PEND_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid, in_ready;
  logic [15:0]       instr;
  logic [DATA_W-1:0] inc_pc;
  logic              reg_write, reg_dst, upper_dest, pc_r7, sign_ext, uses_rs, uses_rt;
  logic              out_valid, out_ready, flush;
  logic [DATA_W-1:0] out_rs_data, out_rt_data, out_imm5, out_imm8, out_inc_pc;
  logic [2:0]        out_dest;
  logic              out_reg_write;
  logic              wb_en;
  logic [2:0]        wb_sel;
  logic [DATA_W-1:0] wb_data;
  logic              err;

  proc_decode_pipe #(.DATA_W(DATA_W), .PEND_W(PEND_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .inc_pc(inc_pc),
    .reg_write(reg_write), .reg_dst(reg_dst), .upper_dest(upper_dest), .pc_r7(pc_r7),
    .sign_ext(sign_ext), .uses_rs(uses_rs), .uses_rt(uses_rt),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm5(out_imm5),
    .out_imm8(out_imm8), .out_dest(out_dest), .out_reg_write(out_reg_write),
    .out_inc_pc(out_inc_pc), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .err(err)
  );

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [2:0]  dest;
    logic        rw;
    logic [15:0] imm5, imm8, rs, rt, pc;
  } exp_t;

  typedef struct {
    logic [15:0] ins;
    logic        p7, ud, rd, sx, rw;
    logic [2:0]  exp_dest;
    logic [15:0] exp_imm5, exp_imm8;
  } vec_t;

  exp_t        sbq[$];
  logic [15:0] rf_m [8];
  logic        rdy_s;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] ext_m(input int val, input int bits, input logic sx);
    int v;
    v = val;
    if (sx && (val >= (1 << (bits - 1)))) v = val - (1 << bits);
    return 16'(v);
  endfunction

  function automatic logic [2:0] dest_m(input logic [15:0] ins, input logic p7, input logic ud,
                                        input logic rd);
    if (p7) return 3'd7;
    if (ud) return ins[10:8];
    if (rd) return ins[7:5];
    return ins[4:2];
  endfunction

  // One clock. Inputs are driven at the negedge before this is called.
  // The task samples the handshake, updates the scoreboard, and returns at the next negedge.
  task automatic cycle();
    exp_t e;
    #1;
    rdy_s = in_ready;
    if (out_valid && flush) begin
      if (sbq.size() > 0) void'(sbq.pop_front());
    end else if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL retire_unexpected: actual=retire required=no retire");
      end else begin
        e = sbq.pop_front();
        check("retire", {out_dest, out_reg_write, out_imm5, out_imm8, out_rs_data, out_rt_data, out_inc_pc},
              {e.dest, e.rw, e.imm5, e.imm8, e.rs, e.rt, e.pc});
      end
    end
    if (in_valid && in_ready && !flush) begin
      e.dest = dest_m(instr, pc_r7, upper_dest, reg_dst);
      e.rw   = reg_write;
      e.imm5 = ext_m(int'(instr[4:0]), 5, sign_ext);
      e.imm8 = ext_m(int'(instr[7:0]), 8, sign_ext);
      e.rs   = rf_m[instr[10:8]];
      e.rt   = rf_m[instr[7:5]];
`ifdef DECODE_BYPASS_EN
      if (wb_en && (wb_sel == instr[10:8])) e.rs = wb_data;
      if (wb_en && (wb_sel == instr[7:5])) e.rt = wb_data;
`endif
      e.pc = inc_pc;
      sbq.push_back(e);
    end
    if (wb_en) rf_m[wb_sel] = wb_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; instr = '0; inc_pc = '0; reg_write = 0; reg_dst = 0; upper_dest = 0;
    pc_r7 = 0; sign_ext = 0; uses_rs = 0; uses_rt = 0; out_ready = 1; flush = 0;
    wb_en = 0; wb_sel = '0; wb_data = '0;
  endtask

  task automatic present(input logic [15:0] i, input logic rw, input logic rd, input logic ud,
                         input logic p7, input logic sx, input logic urs, input logic urt,
                         input logic [15:0] pc);
    in_valid = 1; instr = i; reg_write = rw; reg_dst = rd; upper_dest = ud; pc_r7 = p7;
    sign_ext = sx; uses_rs = urs; uses_rt = urt; inc_pc = pc;
  endtask

  task automatic clear_model();
    sbq.delete();
    for (int r = 0; r < 8; r++) rf_m[r] = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    clear_model();
    #1;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{16'h0000, 1, 1, 0, 0, 0, 3'd7, 16'h0000, 16'h0000};
    tbl[1] = '{16'h035A, 0, 1, 0, 1, 0, 3'd3, 16'hFFFA, 16'h005A};
    tbl[2] = '{16'h035A, 0, 0, 1, 0, 0, 3'd2, 16'h001A, 16'h005A};
    tbl[3] = '{16'h035A, 0, 0, 0, 1, 0, 3'd6, 16'hFFFA, 16'h005A};
    tbl[4] = '{16'h06F0, 0, 0, 0, 1, 0, 3'd4, 16'hFFF0, 16'hFFF0};
    tbl[5] = '{16'h06F0, 0, 0, 1, 0, 0, 3'd7, 16'h0010, 16'h00F0};
    tbl[6] = '{16'h070F, 1, 0, 1, 1, 0, 3'd7, 16'h000F, 16'h000F};
    tbl[7] = '{16'h0180, 0, 0, 1, 1, 1, 3'd4, 16'h0000, 16'hFF80};

    rst = 1;
    idle();
    clear_model();
    @(negedge clk);
    do_reset();
    check("reset_state", {out_valid, err, in_ready, out_dest, out_rs_data, out_imm8, out_inc_pc},
          {1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 16'h0000, 16'h0000});

    // Back-to-back table vectors: one result per cycle
    for (int k = 0; k < 8; k++) begin
      present(tbl[k].ins, tbl[k].rw, tbl[k].rd, tbl[k].ud, tbl[k].p7, tbl[k].sx, 0, 0,
              16'(16'h1000 + 2 * k));
      cycle();
      check($sformatf("vec%0d_ready", k), rdy_s, 1'b1);
      #1;
      check($sformatf("vec%0d_out", k), {out_valid, out_dest, out_imm5, out_imm8},
            {1'b1, tbl[k].exp_dest, tbl[k].exp_imm5, tbl[k].exp_imm8});
    end
    idle();
    cycle();
    check("table_drain", sbq.size(), 0);

    // Reset mid-stream
    do_reset();
    wb_en = 1; wb_sel = 3'd3; wb_data = 16'h1234;
    cycle();
    idle();
    check("rst_err_before", err, 1'b1);
    out_ready = 0;
    present(16'h0123, 0, 0, 0, 0, 0, 0, 0, 16'h0200);
    cycle();
    check("rst_valid_before", out_valid, 1'b1);
    rst = 0;
    #1;
    check("rst_async_clear", {out_valid, err}, 2'b00);
    clear_model();
    @(negedge clk);
    rst = 1;
    idle();
    present(16'h0300, 0, 0, 0, 0, 0, 1, 0, 16'h0300);
    cycle();
    check("rst_r3_zero", out_rs_data, 16'h0000);
    idle();
    cycle();

    // Load-use on R2
    do_reset();
    present(16'h0200, 1, 0, 1, 0, 0, 0, 0, 16'h0400);
    cycle();
    present(16'h0200, 0, 0, 0, 0, 0, 1, 0, 16'h0402);
    cycle();
    check("lu_idex_hazard", rdy_s, 1'b0);
    cycle();
    check("lu_pend_hazard", rdy_s, 1'b0);
    wb_en = 1; wb_sel = 3'd2; wb_data = 16'hBEEF;
    cycle();
    wb_en = 0;
`ifdef DECODE_BYPASS_EN
    check("lu_wb_cycle_ready", rdy_s, 1'b1);
`else
    check("lu_wb_cycle_ready", rdy_s, 1'b0);
    cycle();
    check("lu_after_wb_ready", rdy_s, 1'b1);
`endif
    check("lu_rs_data", out_rs_data, 16'hBEEF);
    idle();
    cycle();
    check("lu_no_err", err, 1'b0);

    // Saturation on R5
    do_reset();
    present(16'h00A0, 1, 1, 0, 0, 0, 0, 0, 16'h0500);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("sat_w%0d_ready", k + 1), rdy_s, 1'b1);
    end
    in_valid = 0;
    cycle();
    present(16'h00A0, 1, 1, 0, 0, 0, 0, 0, 16'h0506);
    cycle();
    check("sat_stall", rdy_s, 1'b0);
    wb_en = 1; wb_sel = 3'd5; wb_data = 16'h5555;
    cycle();
    check("sat_stall_wb_cycle", rdy_s, 1'b0);
    wb_en = 0;
    cycle();
    check("sat_release", rdy_s, 1'b1);
    idle();
    cycle();
    check("sat_no_err", err, 1'b0);

    // Flush of an ID/EX writer to R4 under backpressure
    do_reset();
    out_ready = 0;
    present(16'h0400, 1, 0, 1, 0, 0, 0, 0, 16'h0600);
    cycle();
    check("flush_valid_before", out_valid, 1'b1);
    idle();
    out_ready = 0;
    flush = 1;
    cycle();
    check("flush_kill", out_valid, 1'b0);
    idle();
    uses_rs = 1; instr = 16'h0400;
    #1;
    check("flush_no_pend", in_ready, 1'b1);
    idle();
    wb_en = 1; wb_sel = 3'd4; wb_data = 16'h4444;
    cycle();
    idle();
    check("flush_err", err, 1'b1);
    present(16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0700);
    flush = 1;
    cycle();
    check("flush_over_accept", out_valid, 1'b0);

    // Downstream backpressure and imm8 extension
    do_reset();
    present(16'h0080, 0, 0, 0, 0, 1, 0, 0, 16'h0800);
    cycle();
    out_ready = 0;
    present(16'h0080, 0, 0, 0, 0, 0, 0, 0, 16'h0802);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("bp%0d_ready", k), rdy_s, 1'b0);
      check($sformatf("bp%0d_stable", k), {out_valid, out_imm8, out_inc_pc, out_dest},
            {1'b1, 16'hFF80, 16'h0800, 3'd0});
    end
    out_ready = 1;
    cycle();
    check("bp_zext_imm8", out_imm8, 16'h0080);
    idle();
    cycle();
    check("final_drain", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
